// File: rtl/alu_cdb_unit_if.sv
// Issue bundle from the reservation station plus the ALU half of the common data bus.
// The master side is the RS/arbiter; the ALU unit attaches through the slave modport.
interface alu_cdb_unit_if #(
  parameter int ROB_BIT = 5
);
  logic [6:0]         alu_op;
  logic [31:0]        Vi;
  logic [31:0]        Vj;
  logic [31:0]        imm;
  logic [ROB_BIT-1:0] rd;
  logic [31:0]        pc;
  logic               Itype;
  logic               alu_busy;
  logic               cdb_grant;
  logic               rs_ready;
  logic [ROB_BIT-1:0] rs_ROB_id;
  logic [31:0]        rs_val;
  logic               br_taken;
  logic [31:0]        br_target;
  logic               overflow_err;

  modport master (
    output alu_op, Vi, Vj, imm, rd, pc, Itype, cdb_grant,
    input  alu_busy, rs_ready, rs_ROB_id, rs_val, br_taken, br_target, overflow_err
  );

  modport slave (
    input  alu_op, Vi, Vj, imm, rd, pc, Itype, cdb_grant,
    output alu_busy, rs_ready, rs_ROB_id, rs_val, br_taken, br_target, overflow_err
  );
endinterface

// File: rtl/alu_cdb_unit.sv
// Integer/branch/jump execute unit with a result FIFO feeding the ALU half of the CDB.
// Optional same-cycle bypass of an empty FIFO is enabled by defining ALU_CDB_BYPASS_EN.
module alu_cdb_unit #(
  parameter int FIFO_BIT = 2,
  parameter int ROB_BIT  = 5
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          rdy_in,
  input  logic          clear_flag,
  alu_cdb_unit_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_BIT;

  typedef struct packed {
    logic [ROB_BIT-1:0] rob_id;
    logic [31:0]        val;
    logic               taken;
    logic [31:0]        target;
  } entry_t;

  function automatic entry_t execute(
    input logic [6:0]         op,
    input logic [31:0]        vi,
    input logic [31:0]        vj,
    input logic [31:0]        im,
    input logic [31:0]        pcv,
    input logic               itype,
    input logic [ROB_BIT-1:0] dest
  );
    entry_t             r;
    logic [31:0]        b;
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic signed [31:0] vj_s;
    logic [4:0]         shamt;
    logic               tk;
    logic               ok;
    b      = itype ? im : vj;
    a_s    = $signed(vi);
    b_s    = $signed(b);
    vj_s   = $signed(vj);
    shamt  = b[4:0];
    tk     = 1'b0;
    ok     = 1'b1;
    r      = '0;
    r.rob_id = dest;
    case (op[6:4])
      3'd1: begin
        case (op[3:0])
          4'd0:    r.val = vi + b;
          4'd1:    r.val = vi - b;
          4'd2:    r.val = vi << shamt;
          4'd3:    r.val = {31'b0, a_s < b_s};
          4'd4:    r.val = {31'b0, vi < b};
          4'd5:    r.val = vi ^ b;
          4'd6:    r.val = vi >> shamt;
          4'd7:    r.val = a_s >>> shamt;
          4'd8:    r.val = vi | b;
          4'd9:    r.val = vi & b;
          default: r.val = 32'd0;
        endcase
      end
      // Branches always compare the two register operands, never the immediate.
      3'd2: begin
        case (op[3:0])
          4'd0:    tk = (vi == vj);
          4'd1:    tk = (vi != vj);
          4'd4:    tk = (a_s < vj_s);
          4'd5:    tk = (a_s >= vj_s);
          4'd6:    tk = (vi < vj);
          4'd7:    tk = (vi >= vj);
          default: ok = 1'b0;
        endcase
        if (ok) begin
          r.val    = {31'b0, tk};
          r.taken  = tk;
          r.target = pcv + im;
        end
      end
      3'd3: begin
        case (op[3:0])
          4'd0: begin
            r.val    = pcv + 32'd4;
            r.taken  = 1'b1;
            r.target = pcv + im;
          end
          4'd1: begin
            r.val    = pcv + 32'd4;
            r.taken  = 1'b1;
            r.target = (vi + im) & ~32'd1;
          end
          4'd2:    r.val = im;
          4'd3:    r.val = pcv + im;
          default: r.val = 32'd0;
        endcase
      end
      default: r.val = 32'd0;
    endcase
    return r;
  endfunction

  entry_t              mem [DEPTH];
  logic [FIFO_BIT-1:0] wr_ptr;
  logic [FIFO_BIT-1:0] rd_ptr;
  logic [FIFO_BIT:0]   count;
  logic                overflow;

  entry_t result;
  entry_t head;
  entry_t bus_entry;
  logic   empty;
  logic   full;
  logic   issue;
  logic   bypass;
  logic   pop;
  logic   push;
  logic   accept;

  assign result = execute(bus.alu_op, bus.Vi, bus.Vj, bus.imm, bus.pc, bus.Itype, bus.rd);

  assign empty = (count == '0);
  assign full  = (count == (FIFO_BIT+1)'(DEPTH));
  assign issue = rst_n_in && rdy_in && !clear_flag && (bus.alu_op != 7'd0);

`ifdef ALU_CDB_BYPASS_EN
  assign bypass = issue && empty;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed result taken by the bus in the same cycle never occupies a slot.
  assign pop    = rdy_in && !empty && bus.cdb_grant;
  assign push   = issue && !(bypass && bus.cdb_grant);
  assign accept = push && (!full || pop);

  assign head      = empty ? entry_t'('0) : mem[rd_ptr];
  assign bus_entry = bypass ? result : head;

  assign bus.rs_ready     = bypass || (rdy_in && !empty);
  assign bus.rs_ROB_id    = bus_entry.rob_id;
  assign bus.rs_val       = bus_entry.val;
  assign bus.br_taken     = bus_entry.taken;
  assign bus.br_target    = bus_entry.target;
  assign bus.alu_busy     = (count >= (FIFO_BIT+1)'(DEPTH - 1));
  assign bus.overflow_err = overflow;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (rdy_in) begin
      if (clear_flag) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (accept) wr_ptr <= wr_ptr + 1'b1;
        if (pop)    rd_ptr <= rd_ptr + 1'b1;
        case ({accept, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        if (push && full && !pop) overflow <= 1'b1;
      end
    end
  end

  // Storage is data-only; occupancy and the empty-gated head keep stale slots invisible.
  always_ff @(posedge clk_in) begin
    if (accept) mem[wr_ptr] <= result;
  end
endmodule

// File: tb/tb_alu_cdb_unit.sv
// Scoreboard bench for alu_cdb_unit: directed issues push expected bus entries,
// a negedge monitor pops and compares every granted broadcast.
module tb_alu_cdb_unit;
  localparam int ROB_BIT = 5;

  typedef struct packed {
    logic [ROB_BIT-1:0] rob_id;
    logic [31:0]        val;
    logic               taken;
    logic [31:0]        target;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst_n_in;
  logic rdy_in;
  logic clear_flag;

  alu_cdb_unit_if #(.ROB_BIT(ROB_BIT)) bus ();

  alu_cdb_unit #(.FIFO_BIT(2), .ROB_BIT(ROB_BIT)) dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .rdy_in     (rdy_in),
    .clear_flag (clear_flag),
    .bus        (bus)
  );

  always #5 clk_in = ~clk_in;

  exp_t sb[$];
  exp_t mon_got;
  exp_t mon_want;
  int   errors = 0;
  int   checks = 0;

  always @(negedge clk_in) begin
    if (rst_n_in && rdy_in && !clear_flag && bus.rs_ready && bus.cdb_grant) begin
      mon_got = {bus.rs_ROB_id, bus.rs_val, bus.br_taken, bus.br_target};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL bcast_unexpected: got id=%0d val=0x%0h taken=%0d tgt=0x%0h, wanted no broadcast",
                 mon_got.rob_id, mon_got.val, mon_got.taken, mon_got.target);
      end else begin
        mon_want = sb.pop_front();
        if (mon_got !== mon_want) begin
          errors++;
          $display("FAIL bcast_id%0d: got id=%0d val=0x%0h taken=%0d tgt=0x%0h, want id=%0d val=0x%0h taken=%0d tgt=0x%0h",
                   mon_want.rob_id, mon_got.rob_id, mon_got.val, mon_got.taken, mon_got.target,
                   mon_want.rob_id, mon_want.val, mon_want.taken, mon_want.target);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rs_ready"},  32'(bus.rs_ready),     32'd0);
    check({tag, "_rob_id"},    32'(bus.rs_ROB_id),    32'd0);
    check({tag, "_rs_val"},    bus.rs_val,            32'd0);
    check({tag, "_br_taken"},  32'(bus.br_taken),     32'd0);
    check({tag, "_br_target"}, bus.br_target,         32'd0);
    check({tag, "_overflow"},  32'(bus.overflow_err), 32'd0);
    check({tag, "_alu_busy"},  32'(bus.alu_busy),     32'd0);
  endtask

  task automatic issue(input logic [6:0] op, input logic [31:0] vi, input logic [31:0] vj,
                       input logic [31:0] im, input logic [31:0] pcv, input logic itype,
                       input logic [ROB_BIT-1:0] dest, input bit expect_it,
                       input logic [31:0] e_val, input logic e_taken, input logic [31:0] e_target);
    bus.alu_op = op;
    bus.Vi     = vi;
    bus.Vj     = vj;
    bus.imm    = im;
    bus.pc     = pcv;
    bus.Itype  = itype;
    bus.rd     = dest;
    if (expect_it) sb.push_back({dest, e_val, e_taken, e_target});
    tick();
    bus.alu_op = 7'd0;
  endtask

  initial begin
    rst_n_in = 1'b0;  rdy_in = 1'b1;  clear_flag = 1'b0;
    bus.alu_op = 7'd0;  bus.Vi = '0;  bus.Vj = '0;  bus.imm = '0;
    bus.rd = '0;  bus.pc = '0;  bus.Itype = 1'b0;  bus.cdb_grant = 1'b0;

    // Reset for two cycles, then idle.
    tick(); tick();
    rst_n_in = 1'b1;
    tick();
    @(negedge clk_in);
    check_idle("reset");

    // Single-op latency with the grant held high.
    tick();
    bus.cdb_grant = 1'b1;
    issue(7'h10, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 5'd3, 1, 32'd12, 1'b0, 32'd0);
    @(negedge clk_in);
    check("add_latency_ready", 32'(bus.rs_ready), 32'd1);
    check("add_latency_id", 32'(bus.rs_ROB_id), 32'd3);
    check("add_latency_val", bus.rs_val, 32'd12);

    // Back-to-back arithmetic, branch, jump and illegal encodings.
    tick();
    issue(7'h11, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, 5'd4, 1, 32'd1, 1'b0, 32'd0);
    issue(7'h12, 32'd1, 32'd31, 32'd0, 32'd0, 1'b0, 5'd5, 1, 32'h8000_0000, 1'b0, 32'd0);
    issue(7'h13, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 5'd6, 1, 32'd1, 1'b0, 32'd0);
    issue(7'h14, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 5'd7, 1, 32'd0, 1'b0, 32'd0);
    issue(7'h15, 32'h0000_F0F0, 32'h0000_0FF0, 32'd0, 32'd0, 1'b0, 5'd8, 1, 32'h0000_FF00, 1'b0, 32'd0);
    issue(7'h16, 32'h8000_0000, 32'd0, 32'd4, 32'd0, 1'b1, 5'd9, 1, 32'h0800_0000, 1'b0, 32'd0);
    issue(7'h17, 32'h8000_0000, 32'd0, 32'd4, 32'd0, 1'b1, 5'd10, 1, 32'hF800_0000, 1'b0, 32'd0);
    issue(7'h18, 32'h0000_F000, 32'h0000_000F, 32'd0, 32'd0, 1'b0, 5'd11, 1, 32'h0000_F00F, 1'b0, 32'd0);
    issue(7'h19, 32'h0000_FF0F, 32'd0, 32'h0000_0FF0, 32'd0, 1'b1, 5'd12, 1, 32'h0000_0F00, 1'b0, 32'd0);
    issue(7'h24, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 1'b0, 5'd13, 1, 32'd1, 1'b1, 32'h120);
    issue(7'h26, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 1'b0, 5'd14, 1, 32'd0, 1'b0, 32'h120);
    issue(7'h20, 32'd5, 32'd6, 32'd5, 32'h200, 1'b1, 5'd15, 1, 32'd0, 1'b0, 32'h205);
    issue(7'h25, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'h40, 1'b0, 5'd16, 1, 32'd1, 1'b1, 32'h30);
    issue(7'h30, 32'd0, 32'd0, 32'h10, 32'h400, 1'b0, 5'd17, 1, 32'h404, 1'b1, 32'h410);
    issue(7'h31, 32'h203, 32'd0, 32'd0, 32'h300, 1'b0, 5'd18, 1, 32'h304, 1'b1, 32'h202);
    issue(7'h32, 32'd0, 32'd0, 32'h1234_5000, 32'h50, 1'b0, 5'd19, 1, 32'h1234_5000, 1'b0, 32'd0);
    issue(7'h33, 32'd0, 32'd0, 32'h2000, 32'h1000, 1'b0, 5'd20, 1, 32'h3000, 1'b0, 32'd0);
    issue(7'h5F, 32'd5, 32'd5, 32'd8, 32'd8, 1'b0, 5'd21, 1, 32'd0, 1'b0, 32'd0);
    issue(7'h22, 32'd1, 32'd1, 32'd8, 32'd8, 1'b0, 5'd22, 1, 32'd0, 1'b0, 32'd0);
    issue(7'h1A, 32'd3, 32'd3, 32'd0, 32'd0, 1'b0, 5'd23, 1, 32'd0, 1'b0, 32'd0);
    tick(); tick();
    @(negedge clk_in);
    check("drain_idle_ready", 32'(bus.rs_ready), 32'd0);

    // Back-pressure and overflow with the grant low.
    tick();
    bus.cdb_grant = 1'b0;
    issue(7'h10, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0, 5'd1, 1, 32'd2, 1'b0, 32'd0);
    issue(7'h10, 32'd2, 32'd2, 32'd0, 32'd0, 1'b0, 5'd2, 1, 32'd4, 1'b0, 32'd0);
    @(negedge clk_in);
    check("bp_busy_at2", 32'(bus.alu_busy), 32'd0);
    tick();
    issue(7'h10, 32'd3, 32'd3, 32'd0, 32'd0, 1'b0, 5'd3, 1, 32'd6, 1'b0, 32'd0);
    @(negedge clk_in);
    check("bp_busy_at3", 32'(bus.alu_busy), 32'd1);
    tick();
    issue(7'h10, 32'd4, 32'd4, 32'd0, 32'd0, 1'b0, 5'd4, 1, 32'd8, 1'b0, 32'd0);
    @(negedge clk_in);
    check("bp_no_ovf_at4", 32'(bus.overflow_err), 32'd0);
    tick();
    issue(7'h10, 32'd5, 32'd5, 32'd0, 32'd0, 1'b0, 5'd5, 0, 32'd0, 1'b0, 32'd0);
    @(negedge clk_in);
    check("bp_ovf_at5", 32'(bus.overflow_err), 32'd1);
    tick();
    bus.cdb_grant = 1'b1;
    tick(); tick(); tick(); tick();
    @(negedge clk_in);
    check("bp_drained_ready", 32'(bus.rs_ready), 32'd0);
    check("bp_ovf_sticky", 32'(bus.overflow_err), 32'd1);

    // Reset in the middle of queued work.
    tick();
    bus.cdb_grant = 1'b0;
    issue(7'h10, 32'd9, 32'd9, 32'd0, 32'd0, 1'b0, 5'd25, 0, 32'd0, 1'b0, 32'd0);
    issue(7'h10, 32'd9, 32'd8, 32'd0, 32'd0, 1'b0, 5'd26, 0, 32'd0, 1'b0, 32'd0);
    rst_n_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    @(negedge clk_in);
    check_idle("mid_reset");

    // Full FIFO with a simultaneous push and pop.
    tick();
    for (int i = 0; i < 4; i++)
      issue(7'h10, 32'd100, 32'(i), 32'd0, 32'd0, 1'b0, 5'(20 + i), 1, 32'(100 + i), 1'b0, 32'd0);
    @(negedge clk_in);
    check("full_busy", 32'(bus.alu_busy), 32'd1);
    tick();
    bus.cdb_grant = 1'b1;
    issue(7'h11, 32'd50, 32'd8, 32'd0, 32'd0, 1'b0, 5'd24, 1, 32'd42, 1'b0, 32'd0);
    bus.cdb_grant = 1'b0;
    @(negedge clk_in);
    check("full_pushpop_no_ovf", 32'(bus.overflow_err), 32'd0);
    tick();
    bus.cdb_grant = 1'b1;
    tick();
    @(negedge clk_in);
    check("full_pushpop_count", 32'(bus.alu_busy), 32'd1);
    tick(); tick(); tick();
    @(negedge clk_in);
    check("full_drained_ready", 32'(bus.rs_ready), 32'd0);

    // Flush with two queued entries and a same-cycle issue.
    tick();
    bus.cdb_grant = 1'b0;
    issue(7'h10, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 5'd28, 0, 32'd0, 1'b0, 32'd0);
    issue(7'h10, 32'd3, 32'd4, 32'd0, 32'd0, 1'b0, 5'd29, 0, 32'd0, 1'b0, 32'd0);
    clear_flag = 1'b1;
    issue(7'h10, 32'd5, 32'd6, 32'd0, 32'd0, 1'b0, 5'd30, 0, 32'd0, 1'b0, 32'd0);
    clear_flag = 1'b0;
    @(negedge clk_in);
    check("flush_ready", 32'(bus.rs_ready), 32'd0);
    check("flush_busy", 32'(bus.alu_busy), 32'd0);
    tick();
    bus.cdb_grant = 1'b1;
    tick(); tick();
    @(negedge clk_in);
    check("flush_nothing_after", 32'(bus.rs_ready), 32'd0);

    // Pause holds the head and ignores issues.
    tick();
    bus.cdb_grant = 1'b0;
    issue(7'h10, 32'd40, 32'd2, 32'd0, 32'd0, 1'b0, 5'd9, 1, 32'd42, 1'b0, 32'd0);
    @(negedge clk_in);
    check("pause_pre_ready", 32'(bus.rs_ready), 32'd1);
    tick();
    rdy_in = 1'b0;
    bus.cdb_grant = 1'b1;
    bus.alu_op = 7'h10;  bus.Vi = 32'd7;  bus.Vj = 32'd7;  bus.rd = 5'd10;
    @(negedge clk_in);
    check("pause_ready", 32'(bus.rs_ready), 32'd0);
    check("pause_head_id", 32'(bus.rs_ROB_id), 32'd9);
    tick();
    bus.alu_op = 7'd0;
    @(negedge clk_in);
    check("pause_head_held", 32'(bus.rs_ROB_id), 32'd9);
    tick();
    rdy_in = 1'b1;
    tick();
    @(negedge clk_in);
    check("pause_after_ready", 32'(bus.rs_ready), 32'd0);

    tick();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_cdb_unit.md
Name: alu_cdb_unit

Overview:
- Execution-side counterpart to the reservation station.
- Consumes the issue bundle the RS drives each cycle (alu_op, Vi, Vj, imm, rd, pc, Itype) and computes integer, branch and jump results.
- Queues results in a small FIFO and broadcasts them on the ALU half of the common data bus (rs_ready/rs_ROB_id/rs_val), under a grant from the CDB arbiter shared with the LSB.

Parameters:
- FIFO_BIT, 2, log2 of result-FIFO depth (DEPTH = 1<<FIFO_BIT).
- ROB_BIT, 5, ROB id width.

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  reset; one clock; synchronous, active-low
- rdy_in  in  1  global pause; low freezes all state
- clear_flag  in  1  mispredict flush
- alu_op  in  7  operation; 0 = no issue this cycle
- Vi  in  32  operand 1
- Vj  in  32  operand 2
- imm  in  32  immediate
- rd  in  ROB_BIT  destination ROB id
- pc  in  32  instruction pc
- Itype  in  1  1: second operand = imm, else Vj
- alu_busy  out  1  back-pressure to RS: count >= DEPTH-1
- cdb_grant  in  1  arbiter grants ALU the bus this cycle
- rs_ready  out  1  broadcast valid
- rs_ROB_id  out  ROB_BIT  broadcast ROB id
- rs_val  out  32  broadcast value
- br_taken  out  1  branch/jump taken
- br_target  out  32  redirect target
- overflow_err  out  1  sticky: an issue was dropped because the FIFO was full

Behaviour:
- Opcode: alu_op[6:4] selects the class; alu_op[3:0] selects the sub-operation. Second operand B = Itype ? imm : Vj.
- Class 1, ARITH, sub-ops:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - Shift amount is B[4:0]. Result goes to val; taken = 0.
- Class 2, BRANCH, sub-ops: 0 BEQ, 1 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU.
  - Compares Vi with Vj; imm is never the compare operand.
  - val = {31'b0, taken}; target = pc+imm.
- Class 3, JUMP/UPPER, sub-ops:
  - 0 JAL: val = pc+4, taken = 1, target = pc+imm.
  - 1 JALR: val = pc+4, taken = 1, target = (Vi+imm) & ~1.
  - 2 LUI: val = imm.
  - 3 AUIPC: val = pc+imm.
- Any other class or sub-op: val = 0, taken = 0, target = 0. The result is still pushed so the ROB entry completes.
- All arithmetic is 32-bit modulo 2^32. Overflow is ignored.
- Push: combinational compute on the issue inputs. The entry {rd, val, taken, target} is written into the FIFO at the clock edge ending the cycle in which alu_op != 0.
- Pop and broadcast:
  - rs_ready = !empty && rdy_in. The FIFO head drives rs_ROB_id, rs_val, br_taken and br_target.
  - Head is popped on an edge where rs_ready && cdb_grant.
  - Without a grant the head holds stable.
- Latency: with the FIFO empty and the grant high, an issue in cycle T is broadcast in cycle T+1.
- Simultaneous push and pop: allowed at any count, including full. The count is unchanged.
- Push while full without a pop: the entry is dropped and overflow_err is set. overflow_err is cleared only by reset.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- clear_flag is high at an edge:
  - Pointers and count are set to 0.
  - That cycle's issue is discarded.
  - rs_ready is 0 in the next cycle.
  - overflow_err is kept.
- rdy_in low: no push, no pop, and rs_ready = 0. Issue inputs in that cycle are ignored; the RS is also frozen.
- Reset (rst_n_in = 0 at an edge), including mid-operation:
  - FIFO empties; count = 0.
  - All outputs read 0: rs_ready, rs_ROB_id, rs_val, br_taken, br_target, overflow_err and alu_busy.
  - Reset takes priority over clear_flag and rdy_in.
- Empty FIFO: head outputs are 0, not stale data.

Optional Feature:
- Macro ALU_CDB_BYPASS_EN.
- When defined and the FIFO is empty (rdy_in=1, clear_flag=0, alu_op!=0):
  - The freshly computed result drives rs_ready=1 and the bus fields combinationally in the same cycle T.
  - If cdb_grant is also high, the result is consumed without entering the FIFO. This gives zero-cycle latency.
  - If the grant is low, the result is pushed as normal.
- When not defined: bus outputs come from the FIFO head only, minimum latency 1 cycle.

Test Plan:
- Reset then idle: rst_n_in=0 for 2 cycles, then release with alu_op=0 -> all outputs 0, alu_busy=0.
- ADD/SUB with grant held high:
  - alu_op=0x10, Vi=5, Vj=7, rd=3 at T -> at T+1 rs_ready=1, rs_ROB_id=3, rs_val=12.
  - SUB with Itype=1, imm=0xFFFFFFFF, Vi=0 -> rs_val=1.
- Branch and jump:
  - BLT with Vi=0xFFFFFFFF, Vj=1, pc=0x100, imm=0x20 -> br_taken=1, br_target=0x120, rs_val=1.
  - JALR with Vi=0x203, imm=0 -> target=0x202, rs_val=pc+4.
- Back-pressure, DEPTH=4, grant low:
  - Issue 3 ops -> alu_busy=1.
  - A 4th op is accepted; a 5th is dropped with overflow_err=1.
  - Raise the grant -> 4 broadcasts in issue order, one per cycle.
- Full with simultaneous push and pop: FIFO full, grant=1 plus a new issue -> count stays 4, no overflow, ordering preserved.
- Flush and pause:
  - 2 entries queued, clear_flag=1 together with an issue -> next cycle rs_ready=0, and the issue never appears.
  - rdy_in=0 with a nonempty FIFO -> rs_ready=0 and the head is retained until rdy_in returns.
